// File: rtl/gray_pkg.sv
// ============================================================================
// Module      : gray_pkg
// Description : Shared Gray-code helpers and width limits for Gray counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

    localparam int GRAY_N_MIN = 2;
    localparam int GRAY_N_MAX = 16;

    // Operands are zero-extended to GRAY_N_MAX; callers truncate the result.
    function automatic logic [GRAY_N_MAX-1:0] bin2gray(input logic [GRAY_N_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_N_MAX-1:0] gray2bin(input logic [GRAY_N_MAX-1:0] g);
        logic [GRAY_N_MAX-1:0] b;
        b[GRAY_N_MAX-1] = g[GRAY_N_MAX-1];
        for (int i = GRAY_N_MAX-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg

`default_nettype wire

// File: rtl/gray2bin_n.sv
// ============================================================================
// Module      : gray2bin_n
// Description : Purely combinational N-bit Gray-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin_n
    import gray_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] g_i,
    output logic [N-1:0] b_o
);

    assign b_o = N'(gray2bin(GRAY_N_MAX'(g_i)));

endmodule : gray2bin_n

`default_nettype wire

// File: rtl/gray_updn_counter.sv
// ============================================================================
// Module      : gray_updn_counter
// Description : Loadable up/down counter with registered Gray and binary
//               outputs and a one-cycle WRAP pulse. Define
//               GRAY_UPDN_COUNTER_SAT_EN to saturate at the limits instead
//               (WRAP then flags a blocked step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_updn_counter
    import gray_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         _RST,
    input  logic         _E,
    input  logic         UP,
    input  logic         _LD,
    input  logic [N-1:0] D,
    output logic [N-1:0] G,
    output logic [N-1:0] B,
    output logic         WRAP
);

    localparam logic [N-1:0] C_MAX = '1;

    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         at_limit;
    logic [N-1:0] dec_w;

    assign at_limit = UP ? (cnt_q == C_MAX) : (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!_LD) begin
            cnt_d = D;
        end else if (!_E) begin
`ifdef GRAY_UPDN_COUNTER_SAT_EN
            // A blocked step holds the count and reports "limit hit".
            if (at_limit) begin
                wrap_d = 1'b1;
            end else begin
                cnt_d = UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
`else
            cnt_d  = UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
            wrap_d = at_limit;
`endif
        end
    end

    assign gray_d = N'(bin2gray(GRAY_N_MAX'(cnt_d)));

    always_ff @(posedge CLK) begin
        if (!_RST) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign B    = cnt_q;
    assign G    = gray_q;
    assign WRAP = wrap_q;

    gray2bin_n #(.N(N)) u_gray_dec (
        .g_i (gray_q),
        .b_o (dec_w)
    );

    a_gray_consistent: assert property (@(posedge CLK) disable iff (!_RST) dec_w == cnt_q);

endmodule : gray_updn_counter

`default_nettype wire

// File: tb/tb_gray_updn_counter.sv
// ============================================================================
// Module      : tb_gray_updn_counter
// Description : Directed vector bench for gray_updn_counter at N=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_updn_counter;

    logic       clk;
    logic       rst_n, e_n, up, ld_n;
    logic [3:0] d;
    logic [3:0] g, b;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    gray_updn_counter #(.N(4)) dut (
        .CLK  (clk),
        ._RST (rst_n),
        ._E   (e_n),
        .UP   (up),
        ._LD  (ld_n),
        .D    (d),
        .G    (g),
        .B    (b),
        .WRAP (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ld_n;
        logic       e_n;
        logic       up;
        logic [3:0] d;
        logic [3:0] b;
        logic [3:0] g;
        logic       w;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [3:0] gtab [16];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic l, input logic e,
                         input logic u, input logic [3:0] dv);
        rst_n = r; ld_n = l; e_n = e; up = u; d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string nm, input logic [3:0] eb,
                           input logic [3:0] eg, input logic ew);
        check({nm, ".B"}, int'(b), int'(eb));
        check({nm, ".G"}, int'(g), int'(eg));
        check({nm, ".WRAP"}, int'(wrap), int'(ew));
    endtask

    initial begin
        logic [3:0] prev_g;
        logic [3:0] eb;
        logic       ew;

        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        //          rst   ld    e     up    d      B      G      W
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 4'h7, 4'h4, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h4, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'h6, 4'h5, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 4'h1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
`ifdef GRAY_UPDN_COUNTER_SAT_EN
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 4'h8, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 4'h8, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 4'h8, 1'b1};
`else
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h2, 4'h3, 1'b0};
`endif

        rst_n = 1'b0; ld_n = 1'b1; e_n = 1'b1; up = 1'b1; d = 4'h0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst_n, vecs[i].ld_n, vecs[i].e_n, vecs[i].up, vecs[i].d);
            expect3($sformatf("vec%0d", i), vecs[i].b, vecs[i].g, vecs[i].w);
        end

        // After saturating at 15, a down-step leaves the limit cleanly.
`ifdef GRAY_UPDN_COUNTER_SAT_EN
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        expect3("sat_leave", 4'hE, 4'h9, 1'b0);
`else
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        expect3("dir_down", 4'h1, 4'h1, 1'b0);
`endif

        // Full up-count from reset, checking single-bit Gray steps.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        expect3("up_rst", 4'h0, 4'h0, 1'b0);
        prev_g = g;
        for (int i = 1; i <= 16; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
`ifdef GRAY_UPDN_COUNTER_SAT_EN
            eb = (i == 16) ? 4'hF : 4'(i);
            ew = (i == 16);
`else
            eb = 4'(i);
            ew = (i == 16);
`endif
            expect3($sformatf("up%0d", i), eb, gtab[eb], ew);
            if (eb != 4'(i - 1)) begin
                check($sformatf("up%0d.onebit", i), $countones(g ^ prev_g), 1);
            end
            prev_g = g;
        end

        // Hold for five cycles.
        apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h5);
        expect3("hold_ld", 4'h5, 4'h7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0, 4'hC);
            expect3($sformatf("hold%0d", i), 4'h5, 4'h7, 1'b0);
        end

        // Reset in the middle of counting, then a clean restart.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        expect3("mid_up", 4'h6, 4'h5, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
        expect3("mid_rst", 4'h0, 4'h0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        expect3("restart1", 4'h1, 4'h1, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        expect3("restart2", 4'h2, 4'h3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gray_updn_counter

`default_nettype wire
